reg_bus_xfer_ctrl: RTL

//  Sequencer/arbiter for the shared 8-bit tri-state register bus. Drives the per-register
//  out_en/write_en strobes of NUM_REGS reg_8t-style registers to move a byte from source

---
 rtl/bus_ctrl_pkg.sv | 49 ++++
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/reg_bus_xfer_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bus_ctrl_pkg.sv
// rtl/bus_ctrl_pkg.sv - shared types and helpers for the register bus transfer controller
//
// Contents:
//   xfer_state_t  transfer sequencer states (IDLE=0, DRIVE=1, WRITE=2, TURN=3)
//   clog2_min1    ceil(log2(value)), never less than 1, usable in parameter context
//   unpack_idx    extract slot `slot` of `width` bits from a packed index vector
//   idx_invalid   true when an index addresses a register that does not exist
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WRITE = 2'd2,
        ST_TURN  = 2'd3
    } xfer_state_t;

    // Widest single index and widest packed request vector the helpers handle.
    localparam int IDX_MAX_W  = 8;
    localparam int PACK_MAX_W = 64;

    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < value) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [IDX_MAX_W-1:0] unpack_idx(
        input logic [PACK_MAX_W-1:0] vec,
        input int                    slot,
        input int                    width
    );
        logic [PACK_MAX_W-1:0] shifted;
        shifted = vec >> (slot * width);
        return shifted[IDX_MAX_W-1:0] & IDX_MAX_W'((1 << width) - 1);
    endfunction

    function automatic logic idx_invalid(
        input logic [IDX_MAX_W-1:0] idx,
        input int                   num_regs
    );
        return int'(idx) >= num_regs;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with internal priority pointer
//
// Ports:
//   clock      in   1       rising-edge clock
//   reset_n    in   1       asynchronous active-low reset; pointer -> N-1
//   req        in   N       request vector
//   update     in   1       load pointer with grant_idx (grant was taken)
//   grant      out  N       one-hot-or-zero combinational grant
//   grant_idx  out  IDX_W   index of the granted requester
//   grant_any  out  1       some requester is granted
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             update,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W-1:0] ptr_q;
    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    int               first;
    int               winner;

    // Rotate the request vector so bit 0 is the requester right after the
    // last winner; the lowest set bit of the rotated vector wins.
    assign req_dbl = {req, req};
    assign req_rot = N'(req_dbl >> (int'(ptr_q) + 1));

    always_comb begin
        first     = 0;
        winner    = 0;
        grant     = '0;
        grant_any = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                first     = j;
                grant_any = 1'b1;
            end
        end
        winner    = (int'(ptr_q) + 1 + first) % N;
        grant_idx = IDX_W'(winner);
        for (int i = 0; i < N; i++) begin
            grant[i] = grant_any && (winner == i);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= IDX_W'(N - 1);
        end else if (update) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/reg_bus_xfer_ctrl.sv
// rtl/reg_bus_xfer_ctrl.sv - sequencer/arbiter moving bytes between registers on a shared tri-state bus
//
// Ports:
//   clock      in   1              rising-edge clock
//   reset_n    in   1              asynchronous active-low reset
//   req_valid  in   NUM_REQ        per-requester transfer request
//   req_src    in   NUM_REQ*SEL_W  source index, requester i at [i*SEL_W +: SEL_W]
//   req_dst    in   NUM_REQ*SEL_W  destination index, same packing
//   req_ready  out  NUM_REQ        combinational grant, only while idle
//   done       out  NUM_REQ        completion pulse to the granted requester
//   err        out  1              pulse when an accepted index was out of range
//   busy       out  1              transfer in progress
//   out_en     out  NUM_REGS       register output enable (single bus driver)
//   write_en   out  NUM_REGS       register write enable
module reg_bus_xfer_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter  int NUM_REGS = 8,
    parameter  int NUM_REQ  = 2,
    localparam int SEL_W    = clog2_min1(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*SEL_W-1:0] req_src,
    input  logic [NUM_REQ*SEL_W-1:0] req_dst,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       done,
    output logic                     err,
    output logic                     busy,
    output logic [NUM_REGS-1:0]      out_en,
    output logic [NUM_REGS-1:0]      write_en
);

    localparam int REQ_W = clog2_min1(NUM_REQ);

    xfer_state_t         state_q, state_d;
    logic [SEL_W-1:0]    src_q, src_d;
    logic [SEL_W-1:0]    dst_q, dst_d;
    logic [REQ_W-1:0]    gnt_q, gnt_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [REQ_W-1:0]    arb_idx;
    logic                arb_any;

    logic                in_idle;
    logic                handshake;
    logic [SEL_W-1:0]    cand_src;
    logic [SEL_W-1:0]    cand_dst;
    logic                cand_bad;

    logic [NUM_REGS-1:0] out_en_d;
    logic [NUM_REGS-1:0] write_en_d;
    logic [NUM_REQ-1:0]  done_d;
    logic                err_d;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (REQ_W)
    ) u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req_valid),
        .update    (handshake),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Ready is held low while reset is asserted so nothing looks granted
    // before the controller is running.
    assign in_idle   = (state_q == ST_IDLE) && reset_n;
    assign req_ready = in_idle ? arb_grant : '0;
    assign handshake = in_idle && arb_any;

    always_comb begin
        cand_src = SEL_W'(unpack_idx(PACK_MAX_W'(req_src), int'(arb_idx), SEL_W));
        cand_dst = SEL_W'(unpack_idx(PACK_MAX_W'(req_dst), int'(arb_idx), SEL_W));
        cand_bad = idx_invalid(IDX_MAX_W'(cand_src), NUM_REGS) ||
                   idx_invalid(IDX_MAX_W'(cand_dst), NUM_REGS);
    end

    // Next state and latch updates. An out-of-range request skips the bus
    // phases entirely and only reports completion from TURN.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        gnt_d   = gnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    src_d   = cand_src;
                    dst_d   = cand_dst;
                    gnt_d   = arb_idx;
                    err_d   = cand_bad;
                    state_d = cand_bad ? ST_TURN : ST_DRIVE;
                end
            end
            ST_DRIVE: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_TURN;
            ST_TURN:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they come straight out of
    // flops, one cycle per phase and glitch-free.
    always_comb begin
        out_en_d   = '0;
        write_en_d = '0;
        done_d     = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if ((state_d == ST_DRIVE || state_d == ST_WRITE) && int'(src_d) == r) begin
                out_en_d[r] = 1'b1;
            end
            if (state_d == ST_WRITE && int'(dst_d) == r) begin
                write_en_d[r] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state_d == ST_TURN && int'(gnt_d) == i) begin
                done_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            gnt_q    <= '0;
            out_en   <= '0;
            write_en <= '0;
            done     <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            gnt_q    <= gnt_d;
            out_en   <= out_en_d;
            write_en <= write_en_d;
            done     <= done_d;
            err      <= err_d;
            busy     <= (state_d != ST_IDLE);
        end
    end

endmodule
